// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register plus IF/ID pipeline register.
// Drives the imem address and latches the returned instruction.
// Ports: clk, rst_n (sync, active low), stall, flush,
//   branch_taken/branch_target, jump/jump_index (redirects),
//   Add (imem address), Instr (imem data),
//   if_id_instr/if_id_pc_plus4/if_id_valid (to decode).
// Optional: IFETCH_MISALIGN_CHECK_EN adds sticky misalign_err.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] Add,
  input  logic [31:0] Instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
`ifdef IFETCH_MISALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic        if_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = {branch_target[31:2], 2'b00};
  // Jump region comes from the j instruction's own PC+4,
  // which is what IF/ID currently holds.
  assign jmp_tgt  = {pp4_q[31:28], jump_index, 2'b00};
  assign redirect = branch_taken | jump;

  always_comb begin
    pc_d = pc_plus4;
    if (branch_taken)
      pc_d = br_tgt;
    else if (jump)
      pc_d = jmp_tgt;
    else if (stall)
      pc_d = pc_q;
  end

  always_comb begin
    instr_d = Instr;
    pp4_d   = pc_plus4;
    valid_d = 1'b1;
    if (redirect || flush) begin
      instr_d = NOP_WORD;
      pp4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
      pp4_d   = pp4_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pp4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q |
                 (branch_taken & (branch_target[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign misalign_err = err_q;
`endif

  assign Add            = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pp4_q;
  assign if_id_valid    = valid_q;

endmodule
